// File: rtl/rv32i_enc_pkg.sv
// Shared definitions for the RV32I field-to-word encoder: format codes, the
// NOP substituted for illegal bundles, and the immediate range limits.
package rv32i_enc_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int IMMB_MIN  = -4096;
    localparam int IMMB_MAX  = 4094;
    localparam int IMMJ_MIN  = -(1 << 20);
    localparam int IMMJ_MAX  = (1 << 20) - 2;

    // Signed range test of a 32-bit two's-complement immediate.
    function automatic logic immInRange(input logic [31:0] imm, input int lo, input int hi);
        return ($signed(imm) >= lo) && ($signed(imm) <= hi);
    endfunction

endpackage

// File: rtl/insn_field_packer.sv
// Combinational packer: assembles an RV32I word from its fields and flags
// bundles whose format or immediate cannot be encoded (those become a NOP).
module insn_field_packer
    import rv32i_enc_pkg::*;
(
    input  logic [2:0]  fmt_i,
    input  logic [6:0]  opcode_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [31:0] imm_i,
    output logic [31:0] insn_o,
    output logic        legal_o
);

    logic [31:0] word;
    logic        legal;

    always_comb begin
        word  = NOP_INSN;
        legal = 1'b0;
        case (fmt_i)
            FMT_R: begin
                word  = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
                legal = 1'b1;
            end
            FMT_I: begin
                word  = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
                legal = immInRange(imm_i, IMM12_MIN, IMM12_MAX);
            end
            FMT_S: begin
                word  = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
                legal = immInRange(imm_i, IMM12_MIN, IMM12_MAX);
            end
            FMT_B: begin
                word  = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                         imm_i[4:1], imm_i[11], opcode_i};
                legal = immInRange(imm_i, IMMB_MIN, IMMB_MAX) && !imm_i[0];
            end
            FMT_U: begin
                word  = {imm_i[31:12], rd_i, opcode_i};
                legal = 1'b1;
            end
            FMT_J: begin
                word  = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
                legal = immInRange(imm_i, IMMJ_MIN, IMMJ_MAX) && !imm_i[0];
            end
            default: begin
                word  = NOP_INSN;
                legal = 1'b0;
            end
        endcase
    end

    assign insn_o  = legal ? word : NOP_INSN;
    assign legal_o = legal;

endmodule

// File: rtl/insn_encoder_loader.sv
// Encodes RV32I field bundles, buffers the words in a 2-entry FIFO and streams
// them with sequential, wrapping word addresses to an instruction-memory port.
module insn_encoder_loader
    import rv32i_enc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    input  logic        addr_clr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_insn,
    output logic [31:0] out_addr,
    output logic        err,
    output logic        err_sticky
);

    localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * (DEPTH - 1));

    logic [31:0] packedInsn;
    logic        packedLegal;

    logic [31:0] mem_q [2];
    logic [31:0] mem_d [2];
    logic        wrPtr_q, wrPtr_d;
    logic        rdPtr_q, rdPtr_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] addr_q, addr_d;
    logic        err_q, err_d;
    logic        errSticky_q, errSticky_d;

    logic push;
    logic pop;

    insn_field_packer u_packer (
        .fmt_i    (in_fmt),
        .opcode_i (in_opcode),
        .funct3_i (in_funct3),
        .funct7_i (in_funct7),
        .rd_i     (in_rd),
        .rs1_i    (in_rs1),
        .rs2_i    (in_rs2),
        .imm_i    (in_imm),
        .insn_o   (packedInsn),
        .legal_o  (packedLegal)
    );

    // Ready depends only on the registered count, so a full FIFO stalls input
    // for one cycle even when the head is being popped.
    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        mem_d       = mem_q;
        wrPtr_d     = wrPtr_q ^ push;
        rdPtr_d     = rdPtr_q ^ pop;
        count_d     = count_q;
        addr_d      = addr_q;
        err_d       = push && !packedLegal;
        errSticky_d = errSticky_q || (push && !packedLegal);

        if (push) begin
            mem_d[wrPtr_q] = packedInsn;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        // A clear wins over the post-pop increment in the same cycle.
        if (addr_clr) begin
            addr_d = BASE_ADDR;
        end else if (pop) begin
            addr_d = (addr_q == LAST_ADDR) ? BASE_ADDR : addr_q + 32'd4;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q[0]    <= '0;
            mem_q[1]    <= '0;
            wrPtr_q     <= 1'b0;
            rdPtr_q     <= 1'b0;
            count_q     <= 2'd0;
            addr_q      <= BASE_ADDR;
            err_q       <= 1'b0;
            errSticky_q <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            addr_q      <= addr_d;
            err_q       <= err_d;
            errSticky_q <= errSticky_d;
        end
    end

    assign out_insn   = mem_q[rdPtr_q];
    assign out_addr   = addr_q;
    assign err        = err_q;
    assign err_sticky = errSticky_q;

endmodule
